// File: rtl/riscv_v_pkg.sv
// Shared types for the vector writeback stage.
// Defines the buffered result entry, the SEW encoding and the datapath widths.
// Ports: none (package only).
package riscv_v_pkg;

  localparam int WB_VLEN    = 128;
  localparam int WB_XLEN    = 32;
  localparam int VLEN_BYTES = WB_VLEN / 8;
  localparam int VL_W       = $clog2(VLEN_BYTES) + 1;
  localparam int VS_W       = $clog2(VLEN_BYTES);

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } riscv_v_sew_e;

  typedef struct packed {
    logic [4:0]            vd;
    logic [4:0]            rd;
    logic [WB_VLEN-1:0]    data;
    logic [WB_XLEN-1:0]    int_data;
    logic [VLEN_BYTES-1:0] mask;
    logic                  masked;
    logic                  is_mask_dst;
    logic                  is_v2i;
    riscv_v_sew_e          sew;
    logic [VL_W-1:0]       vl;
    logic [VS_W-1:0]       vstart;
    logic                  vta;
    logic                  vma;
  } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_wb_byte_en.sv
// Byte-enable and data-merge generator for one vector result.
// Purely combinational: classifies each byte as prestart/body/tail and applies
// the mask and tail/mask-agnostic policies; mask destinations write all bytes.
// Ports: data_i/mask_i/masked_i/is_mask_dst_i/sew_i/vl_i/vstart_i/vta_i/vma_i in,
//        wbe_o (per-byte enable) and wdata_o (merged data) out.
module riscv_v_wb_byte_en
  import riscv_v_pkg::*;
(
  input  logic [WB_VLEN-1:0]    data_i,
  input  logic [VLEN_BYTES-1:0] mask_i,
  input  logic                  masked_i,
  input  logic                  is_mask_dst_i,
  input  riscv_v_sew_e          sew_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic [VS_W-1:0]       vstart_i,
  input  logic                  vta_i,
  input  logic                  vma_i,
  output logic [VLEN_BYTES-1:0] wbe_o,
  output logic [WB_VLEN-1:0]    wdata_o
);

  logic [VS_W-1:0] elem;
  logic            elem_active;

  always_comb begin
    wbe_o       = '0;
    wdata_o     = data_i;
    elem        = '0;
    elem_active = 1'b0;
    if (is_mask_dst_i) begin
      // Mask results are one bit per element and the tail is always agnostic.
      wbe_o = '1;
      for (int j = 0; j < WB_VLEN; j++) begin
        if (j >= int'(vl_i)) wdata_o[j] = 1'b1;
      end
    end else begin
      for (int b = 0; b < VLEN_BYTES; b++) begin
        // Element owning this byte: byte index divided by the element size.
        elem        = VS_W'(b >> int'(sew_i));
        elem_active = !masked_i || mask_i[elem];
        if (elem < vstart_i) begin
          wbe_o[b] = 1'b0;
        end else if ({1'b0, elem} < vl_i) begin
          if (elem_active) begin
            wbe_o[b] = 1'b1;
          end else if (vma_i) begin
            wbe_o[b]           = 1'b1;
            wdata_o[b*8 +: 8]  = 8'hFF;
          end
        end else if (vta_i) begin
          wbe_o[b]          = 1'b1;
          wdata_o[b*8 +: 8] = 8'hFF;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_v_writeback.sv
// Vector writeback stage: buffers execute results in a small FIFO and commits
// them to the VRF (through a grant handshake) or the integer RF (single cycle).
// Ports: in_* result interface with in_valid/in_ready; vrf_* write port with
//        vrf_gnt; irf_* integer write; wb_done/wb_done_vd retire pulse; busy.
module riscv_v_writeback
  import riscv_v_pkg::*;
#(
  // VLEN/XLEN must match the widths baked into riscv_v_pkg.
  parameter int VLEN       = WB_VLEN,
  parameter int XLEN       = WB_XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_vd,
  input  logic [4:0]                   in_rd,
  input  logic [VLEN-1:0]              in_data,
  input  logic [XLEN-1:0]              in_int_data,
  input  logic [VLEN/8-1:0]            in_mask,
  input  logic                         in_masked,
  input  logic                         in_is_mask_dst,
  input  logic                         in_is_v2i,
  input  logic [1:0]                   in_sew,
  input  logic [$clog2(VLEN/8):0]      in_vl,
  input  logic [$clog2(VLEN/8)-1:0]    in_vstart,
  input  logic                         in_vta,
  input  logic                         in_vma,
  output logic                         vrf_we,
  input  logic                         vrf_gnt,
  output logic [4:0]                   vrf_waddr,
  output logic [VLEN-1:0]              vrf_wdata,
  output logic [VLEN/8-1:0]            vrf_wbe,
  output logic                         irf_we,
  output logic [4:0]                   irf_waddr,
  output logic [XLEN-1:0]              irf_wdata,
  output logic                         wb_done,
  output logic [4:0]                   wb_done_vd,
  output logic                         busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VWAIT = 1'b1
  } wb_state_e;

  riscv_v_wb_entry_t     fifo_mem [FIFO_DEPTH];
  riscv_v_wb_entry_t     in_entry;
  riscv_v_wb_entry_t     head;

  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  wb_state_e             state_q, state_d;

  logic                  vrf_we_q, vrf_we_d;
  logic [4:0]            vrf_waddr_q, vrf_waddr_d;
  logic [VLEN-1:0]       vrf_wdata_q, vrf_wdata_d;
  logic [VLEN/8-1:0]     vrf_wbe_q, vrf_wbe_d;
  logic                  irf_we_q, irf_we_d;
  logic [4:0]            irf_waddr_q, irf_waddr_d;
  logic [XLEN-1:0]       irf_wdata_q, irf_wdata_d;

  logic                  push, pop;
  logic [VLEN_BYTES-1:0] head_wbe;
  logic [WB_VLEN-1:0]    head_wdata;

  always_comb begin
    in_entry             = '0;
    in_entry.vd          = in_vd;
    in_entry.rd          = in_rd;
    in_entry.data        = in_data;
    in_entry.int_data    = in_int_data;
    in_entry.mask        = in_mask;
    in_entry.masked      = in_masked;
    in_entry.is_mask_dst = in_is_mask_dst;
    in_entry.is_v2i      = in_is_v2i;
    in_entry.sew         = riscv_v_sew_e'(in_sew);
    in_entry.vl          = in_vl;
    in_entry.vstart      = in_vstart;
    in_entry.vta         = in_vta;
    in_entry.vma         = in_vma;
  end

  // No pop-to-push bypass: a full FIFO refuses input even if it pops this cycle.
  assign in_ready = (count_q < CNT_W'(FIFO_DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign head     = fifo_mem[rptr_q];
  // The output register is free when idle, or when its held write is granted now.
  assign pop      = (count_q != '0) && !flush &&
                    ((state_q == ST_EMPTY) || ((state_q == ST_VWAIT) && vrf_gnt));

  riscv_v_wb_byte_en u_byte_en (
    .data_i        (head.data),
    .mask_i        (head.mask),
    .masked_i      (head.masked),
    .is_mask_dst_i (head.is_mask_dst),
    .sew_i         (head.sew),
    .vl_i          (head.vl),
    .vstart_i      (head.vstart),
    .vta_i         (head.vta),
    .vma_i         (head.vma),
    .wbe_o         (head_wbe),
    .wdata_o       (head_wdata)
  );

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    state_d     = state_q;
    vrf_we_d    = vrf_we_q;
    vrf_waddr_d = vrf_waddr_q;
    vrf_wdata_d = vrf_wdata_q;
    vrf_wbe_d   = vrf_wbe_q;
    irf_we_d    = 1'b0;
    irf_waddr_d = irf_waddr_q;
    irf_wdata_d = irf_wdata_q;

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);

    if ((state_q == ST_VWAIT) && vrf_gnt) begin
      state_d  = ST_EMPTY;
      vrf_we_d = 1'b0;
    end

    if (pop) begin
      if (head.is_v2i) begin
        irf_we_d    = 1'b1;
        irf_waddr_d = head.rd;
        irf_wdata_d = head.int_data;
        state_d     = ST_EMPTY;
      end else begin
        vrf_we_d    = 1'b1;
        vrf_waddr_d = head.vd;
        vrf_wdata_d = head_wdata;
        vrf_wbe_d   = head_wbe;
        state_d     = ST_VWAIT;
      end
    end

    if (flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      state_d  = ST_EMPTY;
      vrf_we_d = 1'b0;
      irf_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_EMPTY;
      vrf_we_q    <= 1'b0;
      vrf_waddr_q <= '0;
      vrf_wdata_q <= '0;
      vrf_wbe_q   <= '0;
      irf_we_q    <= 1'b0;
      irf_waddr_q <= '0;
      irf_wdata_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      vrf_we_q    <= vrf_we_d;
      vrf_waddr_q <= vrf_waddr_d;
      vrf_wdata_q <= vrf_wdata_d;
      vrf_wbe_q   <= vrf_wbe_d;
      irf_we_q    <= irf_we_d;
      irf_waddr_q <= irf_waddr_d;
      irf_wdata_q <= irf_wdata_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= in_entry;
  end

  // A flush in the same cycle suppresses the pending write and its retire pulse.
  assign vrf_we     = vrf_we_q && !flush;
  assign irf_we     = irf_we_q && !flush;
  assign vrf_waddr  = vrf_waddr_q;
  assign vrf_wdata  = vrf_wdata_q;
  assign vrf_wbe    = vrf_wbe_q;
  assign irf_waddr  = irf_waddr_q;
  assign irf_wdata  = irf_wdata_q;
  assign wb_done    = !flush && (irf_we_q || (vrf_we_q && vrf_gnt));
  assign wb_done_vd = irf_we_q ? irf_waddr_q : vrf_waddr_q;
  assign busy       = (count_q != '0) || vrf_we_q || irf_we_q;

endmodule

// File: tb/tb_riscv_v_writeback.sv
`timescale 1ns/1ps
module tb_riscv_v_writeback;
  import riscv_v_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_vd = '0, in_rd = '0;
  logic [127:0] in_data = '0;
  logic [31:0]  in_int_data = '0;
  logic [15:0]  in_mask = '0;
  logic         in_masked = 1'b0, in_is_mask_dst = 1'b0, in_is_v2i = 1'b0;
  logic [1:0]   in_sew = '0;
  logic [4:0]   in_vl = '0;
  logic [3:0]   in_vstart = '0;
  logic         in_vta = 1'b0, in_vma = 1'b0;
  logic         vrf_we, vrf_gnt = 1'b0;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic [15:0]  vrf_wbe;
  logic         irf_we;
  logic [4:0]   irf_waddr;
  logic [31:0]  irf_wdata;
  logic         wb_done;
  logic [4:0]   wb_done_vd;
  logic         busy;

  riscv_v_writeback #(.VLEN(128), .XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_vd(in_vd), .in_rd(in_rd), .in_data(in_data), .in_int_data(in_int_data),
    .in_mask(in_mask), .in_masked(in_masked), .in_is_mask_dst(in_is_mask_dst),
    .in_is_v2i(in_is_v2i), .in_sew(in_sew), .in_vl(in_vl), .in_vstart(in_vstart),
    .in_vta(in_vta), .in_vma(in_vma), .vrf_we(vrf_we), .vrf_gnt(vrf_gnt),
    .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata), .vrf_wbe(vrf_wbe),
    .irf_we(irf_we), .irf_waddr(irf_waddr), .irf_wdata(irf_wdata),
    .wb_done(wb_done), .wb_done_vd(wb_done_vd), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit           is_irf;
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic [31:0]  idata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   checks = 0;
  int   failures = 0;
  int   gnt_mode = 0;   // 0: grant high, 1: grant low, 2: random grant

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [127:0] bytemask(input logic [15:0] be);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Reference: walk the elements of the result and apply the policy rules.
  function automatic exp_t build_exp(input riscv_v_wb_entry_t e);
    exp_t x;
    int s, nel;
    bit wr, ones;
    x.is_irf = e.is_v2i;
    x.addr   = e.is_v2i ? e.rd : e.vd;
    x.idata  = e.int_data;
    x.data   = e.data;
    x.be     = '0;
    if (e.is_v2i) return x;
    if (e.is_mask_dst) begin
      x.be = '1;
      for (int j = int'(e.vl); j < 128; j++) x.data[j] = 1'b1;
      return x;
    end
    s   = 1 << int'(e.sew);
    nel = 16 / s;
    for (int i = 0; i < nel; i++) begin
      wr = 0;
      ones = 0;
      if (i < int'(e.vstart)) wr = 0;
      else if (i < int'(e.vl)) begin
        if (!e.masked || e.mask[i]) wr = 1;
        else if (e.vma) begin wr = 1; ones = 1; end
      end else if (e.vta) begin
        wr = 1;
        ones = 1;
      end
      for (int k = 0; k < s; k++) begin
        x.be[i*s+k] = wr;
        if (ones) x.data[(i*s+k)*8 +: 8] = 8'hFF;
      end
    end
    return x;
  endfunction

  function automatic riscv_v_wb_entry_t rand_entry();
    riscv_v_wb_entry_t e;
    int nel;
    e             = '0;
    e.vd          = 5'($urandom);
    e.rd          = 5'($urandom);
    e.data        = {$urandom, $urandom, $urandom, $urandom};
    e.int_data    = $urandom;
    e.mask        = 16'($urandom);
    e.masked      = 1'($urandom_range(0, 1));
    e.is_v2i      = ($urandom_range(0, 5) == 0);
    e.is_mask_dst = !e.is_v2i && ($urandom_range(0, 5) == 0);
    e.sew         = riscv_v_sew_e'(2'($urandom_range(0, 2)));
    nel           = 16 >> int'(e.sew);
    e.vl          = 5'($urandom_range(0, e.is_mask_dst ? 16 : nel));
    e.vstart      = 4'($urandom_range(0, nel - 1));
    e.vta         = 1'($urandom_range(0, 1));
    e.vma         = 1'($urandom_range(0, 1));
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input riscv_v_wb_entry_t e);
    int tries = 0;
    in_valid = 1'b1; in_vd = e.vd; in_rd = e.rd; in_data = e.data;
    in_int_data = e.int_data; in_mask = e.mask; in_masked = e.masked;
    in_is_mask_dst = e.is_mask_dst; in_is_v2i = e.is_v2i; in_sew = e.sew;
    in_vl = e.vl; in_vstart = e.vstart; in_vta = e.vta; in_vma = e.vma;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(build_exp(e));
        break;
      end
      tries++;
      if (tries > 300) begin
        checks++; failures++;
        $display("FAIL send_timeout in_ready=0 required=1 within 300 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 500);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (gnt_mode)
        0: vrf_gnt = 1'b1;
        1: vrf_gnt = 1'b0;
        default: vrf_gnt = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: retire order, contents, retire pulse and hold stability.
  logic         hold_prev = 1'b0;
  logic [4:0]   hold_addr;
  logic [127:0] hold_data;
  logic [15:0]  hold_be;

  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && !flush) begin
        chk("hold_we", 128'(vrf_we), 128'(1));
        chk("hold_addr", 128'(vrf_waddr), 128'(hold_addr));
        chk("hold_data", vrf_wdata, hold_data);
        chk("hold_be", 128'(vrf_wbe), 128'(hold_be));
      end
      if (vrf_we && irf_we) chk("both_we", 128'(irf_we), 128'(0));
      if (vrf_we && vrf_gnt) begin
        if (exp_q.size() == 0) chk("vrf_unexpected", 128'(vrf_we), 128'(0));
        else begin
          mon_x = exp_q.pop_front();
          chk("vrf_kind", 128'(mon_x.is_irf), 128'(0));
          chk("vrf_waddr", 128'(vrf_waddr), 128'(mon_x.addr));
          chk("vrf_wbe", 128'(vrf_wbe), 128'(mon_x.be));
          chk("vrf_wdata", vrf_wdata & bytemask(mon_x.be), mon_x.data & bytemask(mon_x.be));
          chk("vrf_done", 128'(wb_done), 128'(1));
          chk("vrf_done_vd", 128'(wb_done_vd), 128'(mon_x.addr));
        end
      end else if (irf_we) begin
        if (exp_q.size() == 0) chk("irf_unexpected", 128'(irf_we), 128'(0));
        else begin
          mon_x = exp_q.pop_front();
          chk("irf_kind", 128'(mon_x.is_irf), 128'(1));
          chk("irf_waddr", 128'(irf_waddr), 128'(mon_x.addr));
          chk("irf_wdata", 128'(irf_wdata), 128'(mon_x.idata));
          chk("irf_done", 128'(wb_done), 128'(1));
          chk("irf_done_vd", 128'(wb_done_vd), 128'(mon_x.addr));
        end
      end else begin
        chk("done_idle", 128'(wb_done), 128'(0));
      end
      hold_prev = vrf_we && !vrf_gnt;
      hold_addr = vrf_waddr;
      hold_data = vrf_wdata;
      hold_be   = vrf_wbe;
    end
  end

  initial begin
    riscv_v_wb_entry_t e;
    int n;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vrf_we", 128'(vrf_we), 128'(0));
    chk("rst_irf_we", 128'(irf_we), 128'(0));
    chk("rst_wb_done", 128'(wb_done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_vrf_waddr", 128'(vrf_waddr), 128'(0));
    chk("rst_vrf_wdata", vrf_wdata, 128'(0));
    chk("rst_vrf_wbe", 128'(vrf_wbe), 128'(0));
    chk("rst_irf_wdata", 128'(irf_wdata), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // SEW=8 full body, with latency check
    e = '0; e.sew = SEW_8; e.vl = 5'd16; e.vd = 5'd3;
    e.data = {$urandom, $urandom, $urandom, $urandom};
    send(e);
    @(negedge clk);
    chk("lat_edge_n", 128'(vrf_we), 128'(0));
    @(negedge clk);
    chk("lat_edge_n1", 128'(vrf_we), 128'(1));
    drain();

    // SEW=32 prestart / masked body / agnostic tail
    e = '0; e.sew = SEW_32; e.vl = 5'd2; e.vstart = 4'd1; e.vta = 1'b1; e.vma = 1'b0;
    e.masked = 1'b1; e.mask = 16'b0010; e.vd = 5'd4;
    e.data = {$urandom, $urandom, $urandom, $urandom};
    send(e);
    drain();

    // Mask destination with vl=5
    e = '0; e.is_mask_dst = 1'b1; e.vl = 5'd5; e.vd = 5'd9; e.data = 128'h15;
    send(e);
    drain();

    // vl=0 with agnostic tail, and undisturbed tail
    e = '0; e.sew = SEW_16; e.vl = 5'd0; e.vta = 1'b1; e.vd = 5'd20;
    e.data = {$urandom, $urandom, $urandom, $urandom};
    send(e);
    e.vta = 1'b0; e.vd = 5'd21;
    send(e);
    drain();

    // Vector-to-integer result
    e = '0; e.is_v2i = 1'b1; e.rd = 5'd7; e.int_data = 32'hDEADBEEF; e.vd = 5'd30;
    send(e);
    drain();

    // Grant withheld: FIFO fills, output holds, order preserved on grant
    gnt_mode = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      e = rand_entry(); e.is_v2i = 1'b0; e.vd = 5'(10 + k);
      send(e);
    end
    @(negedge clk);
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_busy", 128'(busy), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    gnt_mode = 0;
    drain();

    // Flush while waiting for grant with two entries buffered
    gnt_mode = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      e = rand_entry(); e.is_v2i = 1'b0; e.vd = 5'(16 + k);
      send(e);
    end
    gnt_mode = 0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("flush_vrf_we", 128'(vrf_we), 128'(0));
      chk("flush_busy", 128'(busy), 128'(0));
      chk("flush_in_ready", 128'(in_ready), 128'(1));
    end
    @(posedge clk); #1;

    // Reset asserted while a write is held
    gnt_mode = 1;
    @(posedge clk); #1;
    e = rand_entry(); e.is_v2i = 1'b0; e.vd = 5'd25;
    send(e);
    n = 0;
    while (!vrf_we && n < 10) begin @(posedge clk); #1; n++; end
    chk("pre_rst_vrf_we", 128'(vrf_we), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_vrf_we", 128'(vrf_we), 128'(0));
    chk("mid_rst_wb_done", 128'(wb_done), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_vrf_waddr", 128'(vrf_waddr), 128'(0));
    chk("mid_rst_vrf_wdata", vrf_wdata, 128'(0));
    chk("mid_rst_vrf_wbe", 128'(vrf_wbe), 128'(0));
    exp_q.delete();
    gnt_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic with random grant
    gnt_mode = 2;
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(rand_entry());
    end
    gnt_mode = 0;
    drain();
    repeat (2) @(negedge clk);
    chk("end_busy", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_v_writeback.md
Name: riscv_v_writeback

Overview:
Vector writeback stage; consumes execute-stage results (vector, mask-producing and vector-to-integer) and commits them to the vector and integer register files. Holds a small elastic FIFO, resolves per-byte write enables from vl/vstart/mask/vta/vma, and arbitrates a single VRF write port through a grant handshake. It is the receiving end of the execute result interface.

Parameters:
VLEN, 128, vector register width in bits
XLEN, 32, integer register width
FIFO_DEPTH, 2, result buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all buffered and pending results
in_valid  in  1  execute result valid
in_ready  out  1  FIFO can accept (not full and not flush)
in_vd  in  5  vector destination register
in_rd  in  5  integer destination register
in_data  in  VLEN  vector result
in_int_data  in  XLEN  scalar result (v2i)
in_mask  in  VLEN/8  per-element mask (bit i = element i)
in_masked  in  1  instruction is masked (vm=0)
in_is_mask_dst  in  1  result is a mask register
in_is_v2i  in  1  write integer RF only
in_sew  in  2  0=8,1=16,2=32 bits
in_vl  in  $clog2(VLEN/8)+1  vector length
in_vstart  in  $clog2(VLEN/8)  start element
in_vta, in_vma  in  1 each  tail/mask agnostic policy
vrf_we  out  1  VRF write request
vrf_gnt  in  1  VRF port granted this cycle
vrf_waddr  out  5
vrf_wdata  out  VLEN
vrf_wbe  out  VLEN/8  byte enables
irf_we  out  1  integer RF write (single cycle, never stalled)
irf_waddr  out  5
irf_wdata  out  XLEN
wb_done  out  1  pulse: result retired
wb_done_vd  out  5  register retired (vd or rd)
busy  out  1  FIFO non-empty or output pending

Behaviour:
- Reset (rst low, async): FIFO pointers/count 0; all out valids (vrf_we, irf_we, wb_done) 0; data/addr outputs 0; busy 0; in_ready 1 after reset release.
- Push on in_valid && in_ready. in_ready = (count<FIFO_DEPTH) && !flush; no same-cycle pop-to-push bypass when full.
- Output register: states EMPTY, VWAIT. Pop FIFO head when EMPTY, or VWAIT && vrf_gnt.
- Popped v2i entry: irf_we=1 next cycle for one cycle, wb_done pulses with rd; state EMPTY.
- Popped vector entry: vrf_we=1 next cycle; state VWAIT; outputs held stable until vrf_gnt; wb_done pulses in grant cycle with vd.
- Latency, empty FIFO, grant asserted: accept edge N, vrf_we high after edge N+1, retire at N+1 cycle; throughput 1/cycle with continuous grant.
- Byte enables, element i, s=2^sew bytes, bytes i*s..i*s+s-1:
  prestart (i<vstart): be=0.
  body active (vstart<=i<vl and (!in_masked or mask[i])): be=1, data=in_data.
  body inactive: vma=0 -> be=0; vma=1 -> be=1, data bytes=0xFF.
  tail (i>=vl): vta=0 -> be=0; vta=1 -> be=1, data=0xFF.
- Mask destination: wbe all ones; bits i>=vl forced 1 (tail always agnostic); bits <vl passed from in_data.
- vl=0: vector write still occurs with computed be (all 0 unless agnostic); retires normally.
- flush: count/pointers cleared, pending output dropped (no write, no wb_done) same edge; concurrent in_valid ignored.
- Simultaneous push and pop when full: push rejected (in_ready low); count unchanged by push.

Decomposition:
- riscv_v_pkg: riscv_v_wb_entry_t struct (vd, rd, data, int_data, mask, flags, sew, vl, vstart, vta, vma); riscv_v_sew_e; VLEN_BYTES constant.
- Sub-module riscv_v_wb_byte_en (combinational be/data-merge generator) instantiated on FIFO head.

Test Plan:
- SEW=8, vl=16, vstart=0, unmasked, vd=3, gnt=1 -> vrf_we after 2 edges, waddr=3, wbe=0xFFFF, wdata=in_data, wb_done_vd=3.
- SEW=32, vl=2, vstart=1, vta=1, vma=0, masked, mask=0b0010 -> wbe=0xFFF0, bytes 8..15 data 0xFF, bytes 4..7 = in_data.
- Mask dst, vl=5, in_data=0x0000_0000_0000_0000_0000_0000_0000_0015 -> wbe all ones, wdata bits[127:5]=1, bits[4:0]=10101.
- gnt held low 4 cycles with 3 pushes -> in_ready low after 2nd push held, outputs stable, then writes in order vd sequence preserved on grant.
- v2i result rd=7, int_data=0xDEADBEEF -> irf_we one cycle, irf_waddr=7, no vrf_we.
- flush while VWAIT with 2 FIFO entries -> no vrf_we/wb_done after flush edge, busy=0; rst low mid-write -> all outputs 0 immediately.
